// File: rtl/fp_conv_pkg.sv
// rtl/fp_conv_pkg.sv - shared constants and fp8 word type for the fp8 <-> two's-complement converters
package fp_conv_pkg;

    localparam int DATA_W  = 12;
    localparam int EXP_W   = 3;
    localparam int FRAC_W  = 4;
    localparam int MAG_W   = 11;
    localparam int MAX_MAG = 1920;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp8_t;

endpackage

// File: rtl/sm_to_twos_comp.sv
// rtl/sm_to_twos_comp.sv - combinational sign-magnitude to two's-complement conversion
module sm_to_twos_comp #(
    parameter int MAG_W  = fp_conv_pkg::MAG_W,
    parameter int DATA_W = fp_conv_pkg::DATA_W
) (
    input  logic              sign,
    input  logic [MAG_W-1:0]  mag,
    output logic [DATA_W-1:0] d
);

    logic [DATA_W-1:0] ext;

    always_comb begin
        ext = {{(DATA_W-MAG_W){1'b0}}, mag};
        // A zero magnitude always yields plain zero; there is no negative zero.
        if (mag == '0)
            d = '0;
        else if (sign)
            d = ~ext + DATA_W'(1);
        else
            d = ext;
    end

endmodule

// File: rtl/fp_to_twos_comp_decoder.sv
// rtl/fp_to_twos_comp_decoder.sv - 2-stage valid/ready decoder from fp8 {S,E,F} to 12-bit two's complement
module fp_to_twos_comp_decoder #(
    parameter int DATA_W = 12,
    parameter int EXP_W  = 3,
    parameter int FRAC_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              S,
    input  logic [EXP_W-1:0]  E,
    input  logic [FRAC_W-1:0] F,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] D,
    output logic              neg_zero,
    output logic [CNT_W-1:0]  conv_count
);

    import fp_conv_pkg::*;

    // Widest magnitude is the significand shifted by the largest exponent.
    localparam int MW = FRAC_W + (1 << EXP_W) - 1;

    fp8_t              in_word;
    logic [MW-1:0]     mag_next;
    logic              s1_valid;
    logic              s1_sign;
    logic [MW-1:0]     s1_mag;
    logic              s1_nz;
    logic              s1_load;
    logic              s2_load;
    logic [DATA_W-1:0] d_next;

    assign in_word  = '{sign: S, exp: E, frac: F};
    assign mag_next = {{(MW-FRAC_W){1'b0}}, in_word.frac} << in_word.exp;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_nz    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            // Bubbles leave the held payload untouched.
            if (in_valid) begin
                s1_sign <= in_word.sign;
                s1_mag  <= mag_next;
                s1_nz   <= in_word.sign && (in_word.frac == '0);
            end
        end
    end

    sm_to_twos_comp #(
        .MAG_W  (MW),
        .DATA_W (DATA_W)
    ) u_sign (
        .sign (s1_sign),
        .mag  (s1_mag),
        .d    (d_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            D         <= '0;
            neg_zero  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                D        <= d_next;
                neg_zero <= s1_nz;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conv_count <= '0;
        else if (out_valid && out_ready)
            conv_count <= conv_count + CNT_W'(1);
    end

endmodule
